// File: rtl/uart_rx_os16.sv
// uart_rx_os16 -- 8N1 UART receiver with 16x oversampling.
//
// Each bit is sampled at oversample counts 7, 8 and 9 and decided by majority
// vote at count 9. A start edge that is no longer low at count 7 is dropped as a
// false start. The received byte is held for the consumer until it is unloaded.
// Framing, overrun and parity status are sticky until the next unload.
//
// Optional feature: define UART_RX_PARITY_EN to receive an even-parity bit
// between the data and stop bits (11-bit frame). Without it the frame is 8N1
// and rx_parity_err never leaves 0.
//
// Parameters:
//   BAUD_DIV       rxclk cycles per oversample tick (1..65535); 16 ticks per bit
// Ports:
//   rxclk          receive clock, rising edge
//   reset          asynchronous active-high reset
//   rx_enable      receiver enable; low forces the FSM to IDLE
//   rx_in          serial line, idle high, asynchronous to rxclk
//   uld_rx_data    one-cycle strobe: consumer unloads the held byte
//   rx_data        last accepted byte
//   rx_empty       high when no unread byte is held
//   rx_frame_err   sticky: stop bit sampled low
//   rx_overrun     sticky: byte completed while the previous one was unread
//   rx_parity_err  sticky: parity mismatch (0 without UART_RX_PARITY_EN)
//   rx_busy        high whenever the FSM is not in IDLE
module uart_rx_os16 #(
    parameter int BAUD_DIV = 1
) (
    input  logic       rxclk,
    input  logic       reset,
    input  logic       rx_enable,
    input  logic       rx_in,
    input  logic       uld_rx_data,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_parity_err,
    output logic       rx_busy
);

    localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic             start_go;
    logic             sync_1, rxs;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic [3:0]       cnt;
    logic [2:0]       bit_idx;
    logic             v7, v8, maj;
    logic             at7, at8, at9, at15;
    logic [7:0]       shreg;
    logic             stop_done, load_pend, stop_bad;
    logic             par_bad;
    logic             busy_q;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Two-flop synchronizer; idles high so reset never looks like a start edge.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            sync_1 <= rx_in;
            rxs    <= sync_1;
        end
    end

    assign tick = (div == DIV_W'(BAUD_DIV - 1));
    assign at7  = tick && (cnt == 4'd7);
    assign at8  = tick && (cnt == 4'd8);
    assign at9  = tick && (cnt == 4'd9);
    assign at15 = tick && (cnt == 4'd15);
    assign maj  = majority3(v7, v8, rxs);

    // Divider restarts on the start edge so tick phase is aligned to the frame.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (start_go || tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        start_go  = 1'b0;
        if (!rx_enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_nxt = START;
                        start_go  = 1'b1;
                    end
                end
                START: begin
                    if (at7 && rxs) begin
                        state_nxt = IDLE;
                    end else if (at15) begin
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (at15 && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (at15) begin
                        state_nxt = STOP;
                    end
                end
`endif
                STOP: begin
                    // Leave at the decision point; the last 6 ticks are skipped
                    // so the next start edge is seen as early as possible.
                    if (at9) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign rx_busy = busy_q;

    // Oversample counter is held at 0 in IDLE, including the IDLE->START edge.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if ((state == IDLE) || (state_nxt == IDLE)) begin
            cnt <= 4'd0;
        end else if (tick) begin
            cnt <= cnt + 4'd1;
        end
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            bit_idx <= 3'd0;
        end else if (state != DATA) begin
            bit_idx <= 3'd0;
        end else if (at15) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            v7    <= 1'b1;
            v8    <= 1'b1;
            shreg <= 8'h00;
        end else begin
            if (at7) begin
                v7 <= rxs;
            end
            if (at8) begin
                v8 <= rxs;
            end
            // LSB arrives first, so bits enter at the MSB and walk down.
            if ((state == DATA) && at9) begin
                shreg <= {maj, shreg[7:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must contain an even number of ones.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            par_bad <= 1'b0;
        end else if ((state == PARITY) && at9) begin
            par_bad <= maj ^ (^shreg);
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    // The stop decision is registered; the load lands on the following edge.
    assign stop_done = (state == STOP) && at9 && rx_enable;

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            load_pend <= 1'b0;
            stop_bad  <= 1'b0;
        end else begin
            load_pend <= stop_done;
            if (stop_done) begin
                stop_bad <= ~maj;
            end
        end
    end

    // A load coincident with an unload wins: the unload frees the slot and the
    // flags restart from this frame's status alone.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            rx_data       <= 8'h00;
            rx_empty      <= 1'b1;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
            rx_parity_err <= 1'b0;
        end else if (load_pend) begin
            if (rx_empty || uld_rx_data) begin
                rx_data  <= shreg;
                rx_empty <= 1'b0;
                if (uld_rx_data) begin
                    rx_frame_err  <= stop_bad;
                    rx_overrun    <= 1'b0;
                    rx_parity_err <= par_bad;
                end else begin
                    rx_frame_err  <= rx_frame_err | stop_bad;
                    rx_parity_err <= rx_parity_err | par_bad;
                end
            end else begin
                rx_overrun    <= 1'b1;
                rx_frame_err  <= rx_frame_err | stop_bad;
                rx_parity_err <= rx_parity_err | par_bad;
            end
        end else if (uld_rx_data) begin
            rx_empty      <= 1'b1;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
            rx_parity_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16 -- directed bench for uart_rx_os16 at BAUD_DIV=1.
// Bytes expected from each frame go into a scoreboard queue when the frame is
// driven; a negedge monitor pops and compares whenever the DUT loads a byte.
module tb_uart_rx_os16;

`ifdef UART_RX_PARITY_EN
    localparam int NBITS    = 11;
    localparam int LOAD_LAT = 174;
    logic par_flip = 1'b0;
`else
    localparam int NBITS    = 10;
    localparam int LOAD_LAT = 158;
`endif

    logic       rxclk       = 1'b0;
    logic       reset       = 1'b1;
    logic       rx_enable   = 1'b0;
    logic       rx_in       = 1'b1;
    logic       uld_rx_data = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_parity_err;
    logic       rx_busy;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned t_start  = 0;
    int unsigned fall_cyc = 0;
    logic [7:0]  sb[$];
    logic        prev_empty = 1'b1;
    logic [7:0]  prev_data  = 8'h00;

    uart_rx_os16 #(.BAUD_DIV(1)) dut (
        .rxclk        (rxclk),
        .reset        (reset),
        .rx_enable    (rx_enable),
        .rx_in        (rx_in),
        .uld_rx_data  (uld_rx_data),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_parity_err(rx_parity_err),
        .rx_busy      (rx_busy)
    );

    always #5 rxclk = ~rxclk;

    always @(posedge rxclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Load monitor: a byte is delivered when rx_empty falls or rx_data changes.
    always @(negedge rxclk) begin
        if (!reset && ((prev_empty && !rx_empty) || (rx_data !== prev_data))) begin
            fall_cyc = cyc;
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_load observed=0x%0h expected=no_load", rx_data);
            end
            if (sb.size() != 0) begin
                check("rx_data_sb", {24'd0, rx_data}, {24'd0, sb.pop_front()});
            end
        end
        prev_empty = rx_empty;
        prev_data  = rx_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic glitch,
                              input logic uld_at_load, input logic push);
        logic [10:0] bits;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9]  = (^d) ^ par_flip;
        bits[10] = stop_v;
`else
        bits[9]  = stop_v;
`endif
        if (push) sb.push_back(d);
        @(posedge rxclk); #1;
        t_start = cyc;
        for (int o = 0; o < 16 * NBITS; o++) begin
            if (o > 0) begin
                @(posedge rxclk); #1;
            end
            rx_in       = bits[o / 16] ^ (glitch && (o / 16 >= 1) && (o / 16 <= 8) && (o % 16 == 9));
            uld_rx_data = uld_at_load && (o == LOAD_LAT - 1);
        end
        @(posedge rxclk); #1;
        rx_in       = 1'b1;
        uld_rx_data = 1'b0;
        repeat (20) @(posedge rxclk);
        #1;
    endtask

    task automatic drive_partial(input logic [7:0] d, input int ncyc);
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        @(posedge rxclk); #1;
        for (int o = 0; o < ncyc; o++) begin
            if (o > 0) begin
                @(posedge rxclk); #1;
            end
            rx_in = bits[o / 16];
        end
    endtask

    task automatic unload();
        @(posedge rxclk); #1;
        uld_rx_data = 1'b1;
        @(posedge rxclk); #1;
        uld_rx_data = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge rxclk);
        #1;
        check("rst_rx_data", {24'd0, rx_data}, 32'h00);
        check("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
        check("rst_frame_err", {31'd0, rx_frame_err}, 32'd0);
        check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
        check("rst_parity_err", {31'd0, rx_parity_err}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        reset     = 1'b0;
        rx_enable = 1'b1;
        repeat (20) @(posedge rxclk);

        // Reset asserted asynchronously in the middle of data bit 3
        drive_partial(8'h99, 16 * 4 + 8);
        check("midframe_busy", {31'd0, rx_busy}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, rx_busy}, 32'd0);
        check("midrst_empty", {31'd0, rx_empty}, 32'd1);
        check("midrst_rx_data", {24'd0, rx_data}, 32'h00);
        rx_in = 1'b1;
        repeat (2) @(posedge rxclk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge rxclk);
        #1;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
        check("3c_empty", {31'd0, rx_empty}, 32'd0);
        unload();

        // Clean 0xA5 with exact load latency
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        check("a5_load_latency", fall_cyc - t_start, LOAD_LAT);
        check("a5_rx_data", {24'd0, rx_data}, 32'hA5);
        check("a5_frame_err", {31'd0, rx_frame_err}, 32'd0);
        check("a5_overrun", {31'd0, rx_overrun}, 32'd0);
        check("a5_parity_err", {31'd0, rx_parity_err}, 32'd0);
        unload();
        check("a5_unload_empty", {31'd0, rx_empty}, 32'd1);

        // 4-cycle low pulse on an idle line: false start
        @(posedge rxclk); #1;
        rx_in = 1'b0;
        repeat (4) @(posedge rxclk);
        #1;
        rx_in = 1'b1;
        check("fs_busy_high", {31'd0, rx_busy}, 32'd1);
        repeat (15) @(posedge rxclk);
        #1;
        check("fs_busy_low", {31'd0, rx_busy}, 32'd0);
        repeat (180) @(posedge rxclk);
        #1;
        check("fs_no_load", {31'd0, rx_empty}, 32'd1);

        // Count-8 glitch on every data bit of 0x5A
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b1);
        check("5a_rx_data", {24'd0, rx_data}, 32'h5A);
        unload();

        // Stop bit low on 0x7E; frame error survives the next frame
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1);
        check("7e_frame_err", {31'd0, rx_frame_err}, 32'd1);
        send_frame(8'h66, 1'b1, 1'b0, 1'b0, 1'b0);
        check("7e_keep_data", {24'd0, rx_data}, 32'h7E);
        check("7e_frame_err_sticky", {31'd0, rx_frame_err}, 32'd1);
        check("7e_overrun", {31'd0, rx_overrun}, 32'd1);
        unload();
        check("7e_uld_frame_err", {31'd0, rx_frame_err}, 32'd0);
        check("7e_uld_overrun", {31'd0, rx_overrun}, 32'd0);
        check("7e_uld_empty", {31'd0, rx_empty}, 32'd1);

        // Overrun: 0x11 then 0x22 without unload
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ovr_rx_data", {24'd0, rx_data}, 32'h11);
        check("ovr_flag", {31'd0, rx_overrun}, 32'd1);
        check("ovr_frame_err", {31'd0, rx_frame_err}, 32'd0);

        // Unload coincident with the load edge of 0x33
        send_frame(8'h33, 1'b1, 1'b0, 1'b1, 1'b1);
        check("coinc_rx_data", {24'd0, rx_data}, 32'h33);
        check("coinc_empty", {31'd0, rx_empty}, 32'd0);
        check("coinc_overrun", {31'd0, rx_overrun}, 32'd0);
        unload();

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
        par_flip = 1'b0;
        check("par_bad_latency", fall_cyc - t_start, LOAD_LAT);
        check("par_bad_flag", {31'd0, rx_parity_err}, 32'd1);
        unload();
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
        check("par_good_flag", {31'd0, rx_parity_err}, 32'd0);
        unload();
`else
        check("par_tied_low", {31'd0, rx_parity_err}, 32'd0);
`endif

        check("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

Single-clock UART receiver with 16x oversampling, majority-vote bit sampling, false-start rejection and sticky framing/overrun status. It is the receive end of the team's 8N1 serial link. It decodes the frames produced by the `uart` transmitter path into bytes held for a host-side unload strobe. It sits between the external `rx_in` pin and the consumer logic, and replaces naive single-sample reception where line noise or clock skew is expected.

## Interface
- `BAUD_DIV`, default 1: `rxclk` cycles per oversample tick; 16 ticks per bit; legal range 1..65535.
- `rxclk`  in  1  receive clock; all state is clocked on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_enable`  in  1  receiver enable; low forces IDLE.
- `rx_in`  in  1  serial line, idle high, asynchronous to `rxclk`.
- `uld_rx_data`  in  1  one-cycle strobe; consumer unloads the held byte.
- `rx_data`  out  8  last accepted byte.
- `rx_empty`  out  1  high when no unread byte is held.
- `rx_frame_err`  out  1  sticky; the stop bit was sampled low.
- `rx_overrun`  out  1  sticky; a byte completed while the previous byte was unread.
- `rx_parity_err`  out  1  sticky parity mismatch; tied 0 unless `UART_RX_PARITY_EN` is defined.
- `rx_busy`  out  1  high in any state other than IDLE.

## Operation
- Input path: `rx_in` passes through a 2-flop synchronizer whose flops reset to 1. All decisions use the synchronizer output `rxs`.
- Tick generator:
  - Divider counts 0..`BAUD_DIV`-1 and produces a one-cycle `tick` on wrap.
  - The divider is cleared on the cycle of the IDLE→START transition.
- A 4-bit sample counter runs 0..15 on ticks.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
  - IDLE: when `rx_enable`=1 and `rxs`=0, go to START with the counter at 0.
  - START: at count 7, if `rxs`=1 this is a false start: return to IDLE, no status change. Otherwise continue; at count 15 go to DATA.
  - DATA: 8 bits, LSB first, 16 ticks each.
    - Each bit takes the majority of `rxs` at counts 7, 8 and 9, decided at count 9.
    - The bit shifts into the shift register from the MSB side.
    - After bit 7, count 15, go to STOP (or to PARITY when enabled).
  - STOP: majority at counts 7/8/9, decided at count 9, then load and go to IDLE. The remaining 6 ticks are skipped so the receiver resynchronises on the next start edge.
- Load rules:
  - Stop bit 0: the byte is still loaded and `rx_frame_err` is set.
  - `rx_empty`=0 at load: the new byte is discarded, `rx_data` is kept, and `rx_overrun` is set.
  - Otherwise `rx_data` takes the shift register and `rx_empty` goes to 0.
- Unload: `uld_rx_data`=1 sets `rx_empty` to 1 and clears all three sticky error flags on the next edge.
- Simultaneous unload and load in the same cycle: the load wins. The new byte is stored, `rx_empty` stays 0, no overrun is flagged, and the error flags reflect the new frame only.
- `rx_enable` falling mid-frame: the next edge goes to IDLE. The partial byte is dropped and no flags change.
- Reset (asynchronous, at any time including mid-frame): state IDLE, counters 0, `rx_data`=0x00, `rx_empty`=1, all error flags 0, `rx_busy`=0, synchronizer flops 1.

## Timing
- Define T0 as the `rxclk` edge at which IDLE sees `rxs`=0. This edge is 2–3 edges after the pin falls.
- The following edge numbers hold for `BAUD_DIV`=1:
  - START count k occurs at T0+1+k.
  - Data bit i, count k occurs at T0+17+16i+k.
  - Stop decision occurs at T0+154.
  - `rx_data`/`rx_empty`/flags update on T0+155. That is +16 with parity.
- `BAUD_DIV`=N: every tick interval scales by N.
- Earliest next start detection is T0+155, with `rx_busy` low at that edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - A PARITY state between DATA and STOP samples one even-parity bit (majority 7/8/9).
  - A mismatch sets `rx_parity_err`. The byte is still loaded under the normal load rules.
  - A frame is 11 bits.
- Not defined: there is no PARITY state, the frame is 8N1, and `rx_parity_err` is constant 0.

## Test plan
- Reset mid-frame: assert `reset` at data bit 3 -> outputs immediately at reset values; the next clean frame 0x3C is received correctly.
- 8N1 frame 0xA5, `BAUD_DIV`=1, clean line -> `rx_data`=0xA5, `rx_empty` falls exactly at T0+155, no flags set; `uld_rx_data` -> `rx_empty`=1.
- Glitches:
  - A 4-tick low pulse on an idle line -> false start, `rx_busy` returns low, no load.
  - A 1-tick inverted glitch at count 8 of each data bit of 0x5A -> still 0x5A.
- Stop bit forced low on 0x7E -> `rx_data`=0x7E, `rx_frame_err`=1; it stays 1 across the next frame until `uld_rx_data`.
- Overrun:
  - Two frames 0x11, 0x22 with no unload -> `rx_data`=0x11, `rx_overrun`=1.
  - `uld_rx_data` coincident with the load edge of 0x33 -> `rx_data`=0x33, `rx_empty`=0, `rx_overrun`=0.
- With `UART_RX_PARITY_EN`: 0x01 sent with parity bit 0 -> `rx_parity_err`=1, load at T0+171; correct parity bit 1 -> flag 0.
